// File: rtl/mem_addr_ctrl_if.sv
// mem_addr_ctrl_if: bus bundle between the controller/datapath and the memory address controller.
//   Controller side (master drives): load_pc, reset_pc, load_addr, addr_sel, mem_cmd, dp_out.
//   RAM side (master drives): ram_dout.
//   Controller outputs (slave drives): ram_addr, ram_din, ram_we, pc, mdata, mem_done, cmd_err.
// The slave modport is the controller block itself; the master modport is its environment.
interface mem_addr_ctrl_if #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 16
);
   logic              load_pc;
   logic              reset_pc;
   logic              load_addr;
   logic              addr_sel;
   logic [1:0]        mem_cmd;
   logic [DATA_W-1:0] dp_out;
   logic [DATA_W-1:0] ram_dout;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic              ram_we;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] mdata;
   logic              mem_done;
   logic              cmd_err;

   modport master (
      output load_pc, reset_pc, load_addr, addr_sel, mem_cmd, dp_out, ram_dout,
      input  ram_addr, ram_din, ram_we, pc, mdata, mem_done, cmd_err
   );

   modport slave (
      input  load_pc, reset_pc, load_addr, addr_sel, mem_cmd, dp_out, ram_dout,
      output ram_addr, ram_din, ram_we, pc, mdata, mem_done, cmd_err
   );
endinterface

// File: rtl/mem_addr_ctrl.sv
// mem_addr_ctrl: program counter, data-address register and a small read/write sequencer
// in front of a synchronous RAM with RD_LAT cycles of read latency.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low reset
//   bus   - mem_addr_ctrl_if slave modport (controller strobes, datapath/RAM data, RAM
//           address/data/write-enable, pc, mdata, mem_done pulse, sticky cmd_err)
module mem_addr_ctrl #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned RD_LAT = 1
) (
   input logic            clk,
   input logic            reset,
   mem_addr_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRdWait, StRdCap, StWr} state_e;

   localparam logic [2:0] WaitInit = 3'(RD_LAT - 1);

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] daddr_q, daddr_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_din_q, ram_din_d;
   logic [DATA_W-1:0] mdata_q, mdata_d;
   logic              cmd_err_q, cmd_err_d;
   logic [ADDR_W-1:0] sel_addr;
   logic              mem_done;
   logic              ram_we;

   // Address registers update every cycle regardless of what the sequencer is doing.
   always_comb begin
      pc_d = pc_q;
      if (bus.load_pc) begin
         pc_d = bus.reset_pc ? '0 : pc_q + 1'b1;
      end
      daddr_d = bus.load_addr ? bus.dp_out[ADDR_W-1:0] : daddr_q;
      sel_addr = bus.addr_sel ? pc_q : daddr_q;
   end

   // Sequencer. The address goes out from ram_addr_q one edge after the command is taken, so
   // even at RD_LAT=1 one RD_WAIT cycle is needed before the RAM data can be captured.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      mdata_d    = mdata_q;
      cmd_err_d  = cmd_err_q;
      mem_done   = 1'b0;
      ram_we     = 1'b0;
      unique case (state_q)
         StIdle: begin
            case (bus.mem_cmd)
               2'b01: begin
                  ram_addr_d = sel_addr;
                  cnt_d      = WaitInit;
                  state_d    = StRdWait;
               end
               2'b10: begin
                  ram_addr_d = sel_addr;
                  ram_din_d  = bus.dp_out;
                  state_d    = StWr;
               end
               2'b11: cmd_err_d = 1'b1;
               default: ;
            endcase
         end
         StRdWait: begin
            if (cnt_q == 3'd0) begin
               state_d = StRdCap;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StRdCap: begin
            mdata_d  = bus.ram_dout;
            mem_done = 1'b1;
            state_d  = StIdle;
         end
         StWr: begin
            ram_we   = 1'b1;
            mem_done = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         pc_q       <= '0;
         daddr_q    <= '0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         mdata_q    <= '0;
         cmd_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pc_q       <= pc_d;
         daddr_q    <= daddr_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         mdata_q    <= mdata_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_din  = ram_din_q;
   assign bus.ram_we   = ram_we;
   assign bus.pc       = pc_q;
   assign bus.mdata    = mdata_q;
   assign bus.mem_done = mem_done;
   assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_mem_addr_ctrl.sv
// tb_mem_addr_ctrl: runs two controllers (RD_LAT=1 and RD_LAT=3) on identical stimulus.
// A transaction-level model predicts each accepted command and queues the expected
// completion; a negedge monitor pops and compares whenever mem_done is seen.
module tb_mem_addr_ctrl;

   typedef struct {
      bit          is_wr;
      logic [8:0]  addr;
      logic [15:0] data;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;
   bit          mon_en = 1'b0;
   logic [15:0] seed;

   // Environment RAMs: untouched words read as init_fn(addr).
   bit [15:0]   wmem [2][512];
   bit          wvld [2][512];
   bit [15:0]   pipe1;
   bit [15:0]   pipe3 [3];

   // Model state.
   logic [8:0]  m_pc;
   logic [8:0]  m_daddr;
   int          m_busy [2];
   bit          m_err [2];
   logic [15:0] m_mem [2][512];
   exp_t        sbq [2][$];
   logic [15:0] exp_md [2];

   mem_addr_ctrl_if #(.ADDR_W(9), .DATA_W(16)) b1 ();
   mem_addr_ctrl_if #(.ADDR_W(9), .DATA_W(16)) b3 ();

   mem_addr_ctrl #(.ADDR_W(9), .DATA_W(16), .RD_LAT(1)) dut1 (
      .clk(clk), .reset(rst_n), .bus(b1)
   );
   mem_addr_ctrl #(.ADDR_W(9), .DATA_W(16), .RD_LAT(3)) dut3 (
      .clk(clk), .reset(rst_n), .bus(b3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] init_fn(input logic [8:0] a);
      if (a == 9'd5) return 16'hBEEF;
      return 16'({7'd0, a} * 16'd40503) ^ seed;
   endfunction

   function automatic logic [15:0] ram_rd(input int d, input logic [8:0] a);
      return wvld[d][a] ? wmem[d][a] : init_fn(a);
   endfunction

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   always @(posedge clk) begin
      if (b1.ram_we) begin
         wmem[0][b1.ram_addr] <= b1.ram_din;
         wvld[0][b1.ram_addr] <= 1'b1;
      end
      if (b3.ram_we) begin
         wmem[1][b3.ram_addr] <= b3.ram_din;
         wvld[1][b3.ram_addr] <= 1'b1;
      end
      pipe1    <= ram_rd(0, b1.ram_addr);
      pipe3[0] <= ram_rd(1, b3.ram_addr);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end

   assign b1.ram_dout = pipe1;
   assign b3.ram_dout = pipe3[2];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // One clock: drive inputs, predict the upcoming edge, then compare pc/cmd_err after it.
   task automatic step(input logic rst, input logic lpc, input logic rpc, input logic laddr,
                       input logic asel, input logic [1:0] cmd, input logic [15:0] dp);
      logic [8:0]  sel;
      int unsigned edge_no;
      exp_t        e;
      rst_n = rst;
      b1.load_pc = lpc;   b3.load_pc = lpc;
      b1.reset_pc = rpc;  b3.reset_pc = rpc;
      b1.load_addr = laddr; b3.load_addr = laddr;
      b1.addr_sel = asel; b3.addr_sel = asel;
      b1.mem_cmd = cmd;   b3.mem_cmd = cmd;
      b1.dp_out = dp;     b3.dp_out = dp;
      edge_no = cyc + 1;
      if (!rst) begin
         m_pc = '0;
         m_daddr = '0;
         for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0;
            m_err[d] = 1'b0;
            sbq[d].delete();
         end
      end else begin
         sel = asel ? m_pc : m_daddr;
         for (int d = 0; d < 2; d++) begin
            if (m_busy[d] != 0) begin
               m_busy[d]--;
            end else if (cmd == 2'b01) begin
               e = '{is_wr: 1'b0, addr: sel, data: m_mem[d][sel], cyc: edge_no + lat(d)};
               sbq[d].push_back(e);
               m_busy[d] = lat(d) + 1;
            end else if (cmd == 2'b10) begin
               e = '{is_wr: 1'b1, addr: sel, data: dp, cyc: edge_no};
               sbq[d].push_back(e);
               m_mem[d][sel] = dp;
               m_busy[d] = 1;
            end else if (cmd == 2'b11) begin
               m_err[d] = 1'b1;
            end
         end
         if (lpc) m_pc = rpc ? 9'd0 : m_pc + 9'd1;
         if (laddr) m_daddr = dp[8:0];
      end
      @(posedge clk);
      #1;
      chk("pc_lat1", b1.pc, m_pc);
      chk("pc_lat3", b3.pc, m_pc);
      chk("cmd_err_lat1", b1.cmd_err, m_err[0]);
      chk("cmd_err_lat3", b3.cmd_err, m_err[1]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0);
   endtask

   task automatic mon(input int d, input logic done, input logic we, input logic [8:0] addr,
                      input logic [15:0] din, input logic [15:0] md);
      exp_t e;
      chk($sformatf("mdata[%0d]", d), md, exp_md[d]);
      checks++;
      if (we !== 1'b0 && done !== 1'b1) begin
         failures++;
         $display("FAIL ram_we_without_done[%0d] got we=%b done=%b", d, we, done);
      end
      if (done === 1'b1) begin
         checks++;
         if (sbq[d].size() == 0) begin
            failures++;
            $display("FAIL unexpected_mem_done[%0d] got done=1 want no transaction (cycle %0d)",
                     d, cyc);
         end else begin
            e = sbq[d].pop_front();
            chk($sformatf("done_cycle[%0d]", d), cyc, e.cyc);
            chk($sformatf("ram_addr[%0d]", d), addr, e.addr);
            chk($sformatf("ram_we[%0d]", d), we, e.is_wr);
            if (e.is_wr) chk($sformatf("ram_din[%0d]", d), din, e.data);
            else if (rst_n) exp_md[d] = e.data;
         end
      end
      if (!rst_n) exp_md[d] = '0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, b1.mem_done, b1.ram_we, b1.ram_addr, b1.ram_din, b1.mdata);
         mon(1, b3.mem_done, b3.ram_we, b3.ram_addr, b3.ram_din, b3.mdata);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] cmd;
      int         r;
      seed = 16'($urandom);
      for (int i = 0; i < 512; i++) begin
         m_mem[0][i] = init_fn(9'(i));
         m_mem[1][i] = init_fn(9'(i));
      end
      exp_md[0] = '0;
      exp_md[1] = '0;

      // Reset state.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 16'hFFFF);
      mon_en = 1'b1;
      chk("rst_ram_addr", b1.ram_addr, 0);
      chk("rst_ram_din", b3.ram_din, 0);
      chk("rst_ram_we", b1.ram_we, 0);
      chk("rst_mem_done", b3.mem_done, 0);
      chk("rst_mdata", b1.mdata, 0);

      // PC count, clear and wrap.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0);
      chk("pc_eq_3", b1.pc, 3);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
      chk("pc_clear", b1.pc, 0);
      for (int i = 0; i < 511; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0);
      chk("pc_eq_511", b3.pc, 511);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0);
      chk("pc_wrap", b3.pc, 0);

      // Read RAM[5] via pc.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'h0);
      idle(6);
      chk("read_pc5_addr", b1.ram_addr, 5);
      chk("read_pc5_mdata", b1.mdata, 16'hBEEF);

      // Write through data-address register.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0123);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 16'hA5A5);
      idle(4);
      chk("write_addr", b1.ram_addr, 9'h123);
      chk("write_din", b1.ram_din, 16'hA5A5);
      chk("write_keeps_mdata", b3.mdata, 16'hBEEF);

      // Held read command, then writes requested while busy.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'h0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 16'h5A5A);
      idle(8);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 9));
         cmd = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : 2'b10;
         step(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) == 0, 1'($urandom), cmd, 16'($urandom));
      end
      idle(8);

      // Illegal command, then reset during a read.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0);
      idle(3);
      chk("illegal_sets_err", b1.cmd_err, 1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0);
      idle(6);
      chk("abort_mdata", b3.mdata, 0);
      chk("abort_cmd_err", b3.cmd_err, 0);
      chk("abort_pc", b1.pc, 0);

      chk("sb_drained_lat1", sbq[0].size(), 0);
      chk("sb_drained_lat3", sbq[1].size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
